// File: rtl/led_ctrl_pkg.sv
// Shared types and default timing for the button control stage and the LED blinker.
package led_ctrl_pkg;

  // Button FSM states
  typedef enum logic [2:0] {
    RELEASED,
    PRESS_DEBOUNCE,
    PRESSED,
    LONG_HELD,
    RELEASE_DEBOUNCE
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned DEF_LONG_CYCLES     = 50000;
  localparam int unsigned DEF_RATE_STEPS      = 4;

  // Blink-rate code driven to the blinker
  typedef logic [$clog2(DEF_RATE_STEPS)-1:0] rate_code_t;

  // LED on-time in clock cycles for each rate code
  function automatic int unsigned rate_on_cycles(rate_code_t code);
    case (code)
      2'd0:    return 32'd25_000_000;
      2'd1:    return 32'd12_500_000;
      2'd2:    return 32'd6_250_000;
      default: return 32'd3_125_000;
    endcase
  endfunction

  // LED off-time in clock cycles for each rate code
  function automatic int unsigned rate_off_cycles(rate_code_t code);
    case (code)
      2'd0:    return 32'd25_000_000;
      2'd1:    return 32'd12_500_000;
      2'd2:    return 32'd6_250_000;
      default: return 32'd3_125_000;
    endcase
  endfunction

endpackage

// File: rtl/button_rate_ctrl_if.sv
// Button input and event/rate outputs of the button control stage.
// master: the control stage; slave: the consumer (blinker) and button source.
interface button_rate_ctrl_if #(
  parameter int unsigned RATE_W = 2
);
  logic              btn_in;
  logic              btn_level;
  logic              press_pulse;
  logic              release_pulse;
  logic              long_pulse;
  logic [RATE_W-1:0] rate_sel;
  logic              blink_en;

  modport master (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_pulse, rate_sel, blink_en
  );

  modport slave (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_pulse, rate_sel, blink_en
  );
endinterface

// File: rtl/button_rate_ctrl_sync_ff_chain.sv
// Multi-stage synchroniser for an asynchronous single-bit input; resets to 0.
module sync_ff_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;

  // Shift the raw input through the flop chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/button_rate_ctrl.sv
// Push-button synchroniser, debouncer and rate/enable controller for the LED blinker.
// Optional long-press support is enabled by defining BUTTON_LONG_PRESS_EN.
module button_rate_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned RATE_STEPS      = DEF_RATE_STEPS
) (
  input  logic                clk,
  input  logic                reset,
  button_rate_ctrl_if.master  bus
);
  localparam int unsigned CNT_W  = $clog2(LONG_CYCLES + 1);
  localparam int unsigned RATE_W = $clog2(RATE_STEPS);
  localparam logic [CNT_W-1:0]  DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(RATE_STEPS - 1);
`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CNT_W-1:0]  LONG_MAX = CNT_W'(LONG_CYCLES - 1);
`endif

  btn_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] rate_next;
  logic              s;
  logic              level_q;
  logic              press_q;
  logic              release_q;
  logic              from_long;
`ifdef BUTTON_LONG_PRESS_EN
  logic              long_q;
  logic              blink_q;
`endif

  sync_ff_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_in),
    .q     (s)
  );

  // Saturating counter step and wrapping rate step
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign rate_next = (rate_q == RATE_MAX) ? '0 : rate_q + RATE_W'(1);

  // Debounce FSM with registered level, event pulses, rate and enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RELEASED;
      cnt       <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      from_long <= 1'b0;
      rate_q    <= '0;
`ifdef BUTTON_LONG_PRESS_EN
      long_q    <= 1'b0;
      blink_q   <= 1'b1;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
      long_q    <= 1'b0;
`endif
      case (state)
        RELEASED: begin
          if (s) begin
            state <= PRESS_DEBOUNCE;
            cnt   <= CNT_W'(1);
          end
        end
        PRESS_DEBOUNCE: begin
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DEB_MAX) begin
            state   <= PRESSED;
            cnt     <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESSED: begin
          if (!s) begin
            state     <= RELEASE_DEBOUNCE;
            cnt       <= CNT_W'(1);
            from_long <= 1'b0;
          end
`ifdef BUTTON_LONG_PRESS_EN
          else if (cnt == LONG_MAX) begin
            state   <= LONG_HELD;
            cnt     <= '0;
            long_q  <= 1'b1;
            blink_q <= ~blink_q;
          end else begin
            cnt <= cnt_inc;
          end
`endif
        end
        LONG_HELD: begin
          if (!s) begin
            state     <= RELEASE_DEBOUNCE;
            cnt       <= CNT_W'(1);
            from_long <= 1'b1;
          end
        end
        RELEASE_DEBOUNCE: begin
          if (s) begin
            state <= from_long ? LONG_HELD : PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_MAX) begin
            state     <= RELEASED;
            cnt       <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
`ifdef BUTTON_LONG_PRESS_EN
            if (!from_long) rate_q <= rate_next;
`else
            rate_q <= rate_next;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.rate_sel      = rate_q;
`ifdef BUTTON_LONG_PRESS_EN
  assign bus.long_pulse    = long_q;
  assign bus.blink_en      = blink_q;
`else
  assign bus.long_pulse    = 1'b0;
  assign bus.blink_en      = 1'b1;
`endif
endmodule

// File: doc/button_rate_ctrl.md
Name: button_rate_ctrl

Overview:
- Upstream control stage for the LED blinker.
- Synchronises and debounces one mechanical push-button.
- Emits clean press, release and long-press events.
- Maintains the blink-rate selection and blink-enable that drive the blinker's on/off timing.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive stable synced cycles required to accept a level change.
- LONG_CYCLES, 50000: cycles held in Pressed, counted from press_pulse, before a long press is declared. Must be greater than DEBOUNCE_CYCLES.
- SYNC_STAGES, 2: flip-flop stages on btn_in. Minimum 2.
- RATE_STEPS, 4: number of rate codes. rate_sel wraps from RATE_STEPS-1 to 0.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: asynchronous, active-low reset.
- btn_in, input, 1: raw button, active-high, asynchronous to clk.
- btn_level, output, 1: debounced button level.
- press_pulse, output, 1: one-cycle pulse on accepted press.
- release_pulse, output, 1: one-cycle pulse on accepted release.
- long_pulse, output, 1: one-cycle pulse when a long press is declared.
- rate_sel, output, $clog2(RATE_STEPS): blink-rate code for the blinker.
- blink_en, output, 1: blinker enable. Blinker holds LED off when 0.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release via clk):
  - state=Released, counters=0, all sync flops=0.
  - btn_level=0, press_pulse=0, release_pulse=0, long_pulse=0, rate_sel=0, blink_en=1.
- All outputs are registered. No combinational path from btn_in.
- Synchronised input: s = btn_in after SYNC_STAGES flops.
- Debounce counter width: $clog2(LONG_CYCLES+1). It saturates and never wraps.
- FSM states: Released, PressDebounce, Pressed, LongHeld, ReleaseDebounce.
  - Released: s=1 → PressDebounce, cnt=1.
  - PressDebounce:
    - s=0 → Released, cnt=0 (glitch rejected, no pulse).
    - s=1 and cnt==DEBOUNCE_CYCLES → Pressed, cnt=0, btn_level=1, press_pulse=1 for the next cycle.
    - Otherwise cnt++.
  - Pressed:
    - s=0 → ReleaseDebounce, cnt=1. The long count is discarded.
    - s=1 and cnt==LONG_CYCLES-1 → LongHeld, long_pulse=1, blink_en toggles.
    - Otherwise cnt++.
  - LongHeld: s=0 → ReleaseDebounce, cnt=1. Otherwise hold with no counting and no repeat pulses.
  - ReleaseDebounce:
    - Entered from Pressed or LongHeld. The origin is recorded in a 1-bit flag.
    - s=1 → return to the origin state. In Pressed the long count restarts at 0.
    - s=0 and cnt==DEBOUNCE_CYCLES → Released, btn_level=0, release_pulse=1.
    - Otherwise cnt++.
- rate_sel update:
  - Advances by 1 modulo RATE_STEPS on release_pulse, only when the origin was Pressed (short press).
  - A long press never changes rate_sel.
- Latency: with btn_in stable high, press_pulse rises SYNC_STAGES+DEBOUNCE_CYCLES+1 clock edges after btn_in is first sampled high. Release latency is symmetric.
- Pulse exclusivity: press_pulse, release_pulse and long_pulse are mutually exclusive in any cycle.
- Reset mid-operation: return immediately to reset values. A partially debounced press is lost. rate_sel and blink_en reinitialise.
- Default FSM branch: go to Released with pulses 0.

Optional Feature:
- Macro: BUTTON_LONG_PRESS_EN.
- Defined: LongHeld state, long_pulse and blink_en toggle behave as above.
- Undefined:
  - Pressed never counts toward LONG_CYCLES, and LongHeld is unreachable or removed.
  - long_pulse is tied 0 and blink_en is tied 1.
  - Every accepted release advances rate_sel.

Decomposition:
- Shared package led_ctrl_pkg holds:
  - the BtnState enum (Released, PressDebounce, Pressed, LongHeld, ReleaseDebounce);
  - the rate code typedef;
  - default timing localparams shared with the blinker (DEBOUNCE_CYCLES, LONG_CYCLES, per-rate on/off times).
- One sub-module: sync_ff_chain, a parameterised SYNC_STAGES synchroniser that resets to 0.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20, SYNC_STAGES=2, RATE_STEPS=4.
1. Clean press: btn_in 0→1 held 30 cycles, then released → press_pulse exactly at edge 7, long_pulse once at Pressed+20, blink_en 1→0, release_pulse after release, rate_sel stays 0.
2. Short press: btn_in high 10 cycles → press_pulse, then release_pulse after 7 edges; rate_sel 0→1. Repeat 4 short presses → rate_sel 1→2→3→0 (wrap).
3. Bounce rejection: btn_in toggles every 2 cycles for 20 cycles, ending low → no pulses, btn_level stays 0, rate_sel unchanged.
4. Release bounce: from Pressed, btn_in low 2 cycles then high → no release_pulse, state returns to Pressed; final clean release → one release_pulse.
5. Reset mid-debounce: reset=0 during PressDebounce with cnt=3 → all outputs at reset values immediately; after reset=1 with btn_in held high, press_pulse 7 edges later.
6. Macro undefined: hold btn_in 100 cycles → long_pulse never asserts, blink_en stays 1, release advances rate_sel by 1.
